// File: rtl/lisp_defs.sv
// Shared Lisp machine constants used by the heap and its clients.
package lisp_defs;

  localparam logic [15:0] LISP_NIL = 16'h8000;

endpackage

// File: rtl/heap_memory.sv
// Word-addressed Lisp heap: READ/WRITE/ALLOC/CLEAR with a bump allocator and a clear sweep.
// Optional feature macro: HEAP_BOUNDS_CHECK_EN (reject addresses >= MemorySize instead of wrapping).
module heap_memory #(
  parameter int DataWidth  = 16,
  parameter int AddrWidth  = 16,
  parameter int MemorySize = 1024,
  parameter int HeapStart  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic [1:0]           op,
  input  logic [AddrWidth-1:0] addr_in,
  input  logic [DataWidth-1:0] data_in,
  input  logic [AddrWidth-1:0] alloc_size,
  output logic                 data_ready,
  output logic [DataWidth-1:0] data_out,
  output logic                 error,
  output logic                 busy,
  output logic [AddrWidth-1:0] heap_ptr
);

  localparam int IdxW = $clog2(MemorySize);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ALLOC = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [DataWidth-1:0] NIL_WORD   = DataWidth'(lisp_defs::LISP_NIL);
  localparam logic [AddrWidth:0]   MEM_SIZE_W = (AddrWidth+1)'(MemorySize);
  localparam logic [AddrWidth-1:0] HEAP_START = AddrWidth'(HeapStart);
  localparam logic [IdxW-1:0]      LAST_IDX   = IdxW'(MemorySize - 1);

  typedef enum logic {
    IDLE     = 1'b0,
    CLEARING = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       clr_idx_q, clr_idx_d;
  logic                  clr_ack_q, clr_ack_d;
  logic [AddrWidth-1:0]  heap_ptr_q, heap_ptr_d;
  logic                  data_ready_q, data_ready_d;
  logic [DataWidth-1:0]  data_out_q, data_out_d;
  logic                  error_q, error_d;

  logic [DataWidth-1:0]  mem [MemorySize];
  logic                  mem_we;
  logic                  mem_wen;
  logic [IdxW-1:0]       mem_waddr;
  logic [DataWidth-1:0]  mem_wdata;

  logic [IdxW-1:0]       idx;
  logic                  oob;
  logic [AddrWidth:0]    alloc_sum;

  assign idx       = IdxW'(addr_in);
  assign alloc_sum = {1'b0, heap_ptr_q} + {1'b0, alloc_size};
  assign mem_wen   = mem_we & ~rst;

`ifdef HEAP_BOUNDS_CHECK_EN
  assign oob = ({1'b0, addr_in} >= MEM_SIZE_W);
`else
  assign oob = 1'b0;
`endif

  // Next-state, response and memory-write decode.
  always_comb begin
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    clr_ack_d    = clr_ack_q;
    heap_ptr_d   = heap_ptr_q;
    data_ready_d = 1'b0;
    data_out_d   = {DataWidth{1'b0}};
    error_d      = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = idx;
    mem_wdata    = data_in;

    case (state_q)
      IDLE: begin
        if (req) begin
          data_ready_d = 1'b1;
          case (op)
            OP_READ: begin
              if (oob) begin
                error_d = 1'b1;
              end else begin
                data_out_d = mem[idx];
              end
            end
            OP_WRITE: begin
              // Address 0 is the permanent NIL cell, also when reached by wrapping.
              if (oob || (idx == {IdxW{1'b0}})) begin
                error_d = 1'b1;
              end else begin
                mem_we = 1'b1;
              end
            end
            OP_ALLOC: begin
              if (alloc_sum > MEM_SIZE_W) begin
                error_d = 1'b1;
              end else begin
                data_out_d = DataWidth'(heap_ptr_q);
                heap_ptr_d = alloc_sum[AddrWidth-1:0];
              end
            end
            OP_CLEAR: begin
              data_ready_d = 1'b0;
              state_d      = CLEARING;
              clr_idx_d    = {IdxW{1'b0}};
              clr_ack_d    = 1'b1;
            end
            default: begin
              error_d = 1'b1;
            end
          endcase
        end else begin
          data_ready_d = 1'b0;
        end
      end
      CLEARING: begin
        mem_we    = 1'b1;
        mem_waddr = clr_idx_q;
        if (clr_idx_q == {IdxW{1'b0}}) begin
          mem_wdata = NIL_WORD;
        end else begin
          mem_wdata = {DataWidth{1'b0}};
        end
        // Reset-initiated sweeps leave clr_ack_q low so they finish silently.
        if (clr_idx_q == LAST_IDX) begin
          state_d      = IDLE;
          data_ready_d = clr_ack_q;
          clr_ack_d    = 1'b0;
          heap_ptr_d   = HEAP_START;
        end else begin
          clr_idx_d = clr_idx_q + {{(IdxW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and response registers with synchronous reset into a fresh sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CLEARING;
      clr_idx_q    <= {IdxW{1'b0}};
      clr_ack_q    <= 1'b0;
      heap_ptr_q   <= HEAP_START;
      data_ready_q <= 1'b0;
      data_out_q   <= {DataWidth{1'b0}};
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      clr_ack_q    <= clr_ack_d;
      heap_ptr_q   <= heap_ptr_d;
      data_ready_q <= data_ready_d;
      data_out_q   <= data_out_d;
      error_q      <= error_d;
    end
  end

  // Heap storage; contents are initialised by the sweep, not by reset.
  always_ff @(posedge clk) begin
    if (mem_wen) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign data_ready = data_ready_q;
  assign data_out   = data_out_q;
  assign error      = error_q;
  assign busy       = (state_q == CLEARING);
  assign heap_ptr   = heap_ptr_q;

endmodule

// File: tb/tb_heap_memory.sv
// Scoreboard bench for heap_memory: stimulus pushes expected responses, a monitor pops on data_ready.
module tb_heap_memory;

  localparam logic [1:0] RD = 2'b00;
  localparam logic [1:0] WR = 2'b01;
  localparam logic [1:0] AL = 2'b10;
  localparam logic [1:0] CL = 2'b11;
  localparam logic [15:0] NIL = lisp_defs::LISP_NIL;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [1:0]  op;
  logic [15:0] addr_in;
  logic [15:0] data_in;
  logic [15:0] alloc_size;
  logic        data_ready;
  logic [15:0] data_out;
  logic        error;
  logic        busy;
  logic [15:0] heap_ptr;

  logic [16:0] exp_q[$];
  logic [16:0] exp_item;
  int          tests = 0;
  int          fails = 0;
  bit          mon_en = 1'b0;
  int          n;

  always #5 clk = ~clk;

  heap_memory dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .op(op),
    .addr_in(addr_in),
    .data_in(data_in),
    .alloc_size(alloc_size),
    .data_ready(data_ready),
    .data_out(data_out),
    .error(error),
    .busy(busy),
    .heap_ptr(heap_ptr)
  );

  // Monitor: every data_ready pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (mon_en) begin
      tests++;
      if (data_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_ready: got data_out=%h error=%b, required no response", data_out, error);
        end else begin
          exp_item = exp_q.pop_front();
          if ({error, data_out} !== exp_item) begin
            fails++;
            $display("FAIL response: got error=%b data_out=%h, required error=%b data_out=%h",
                     error, data_out, exp_item[16], exp_item[15:0]);
          end
        end
      end else if (data_ready !== 1'b0 || data_out !== 16'h0000 || error !== 1'b0) begin
        fails++;
        $display("FAIL idle_outputs: got ready=%b data_out=%h error=%b, required 0/0000/0",
                 data_ready, data_out, error);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] d,
                       input logic [15:0] s, input bit expect_resp,
                       input logic [15:0] exp_data, input logic exp_err);
    req        = 1'b1;
    op         = o;
    addr_in    = a;
    data_in    = d;
    alloc_size = s;
    if (expect_resp) exp_q.push_back({exp_err, exp_data});
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic wait_sweep(output int cycles);
    cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (busy === 1'b1) cycles++;
      else break;
    end
    if (cycles >= 3000) begin
      fails++;
      $display("FAIL sweep_timeout: busy still high after %0d cycles", cycles);
    end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; op = RD; addr_in = 16'h0; data_in = 16'h0; alloc_size = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    check("reset_heap_ptr", 32'(heap_ptr), 32'd1);
    check("reset_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    wait_sweep(n);
    check("reset_sweep_len", n, 32'd1024);
    check("post_reset_heap_ptr", 32'(heap_ptr), 32'd1);

    issue(RD, 16'h0000, 16'h0, 16'h0, 1'b1, NIL, 1'b0);
    issue(RD, 16'h0005, 16'h0, 16'h0, 1'b1, 16'h0000, 1'b0);
    issue(WR, 16'h0010, 16'hBEEF, 16'h0, 1'b1, 16'h0000, 1'b0);
    issue(RD, 16'h0010, 16'h0, 16'h0, 1'b1, 16'hBEEF, 1'b0);
    issue(AL, 16'h0, 16'h0, 16'd2, 1'b1, 16'd1, 1'b0);
    issue(AL, 16'h0, 16'h0, 16'd3, 1'b1, 16'd3, 1'b0);
    check("heap_ptr_after_allocs", 32'(heap_ptr), 32'd6);
    issue(AL, 16'h0, 16'h0, 16'd0, 1'b1, 16'd6, 1'b0);
    check("heap_ptr_alloc_zero", 32'(heap_ptr), 32'd6);
    issue(WR, 16'h0000, 16'h1234, 16'h0, 1'b1, 16'h0000, 1'b1);
    issue(RD, 16'h0000, 16'h0, 16'h0, 1'b1, NIL, 1'b0);
    issue(WR, 16'h0400, 16'hAAAA, 16'h0, 1'b1, 16'h0000, 1'b1);
`ifdef HEAP_BOUNDS_CHECK_EN
    issue(WR, 16'h0401, 16'hAAAA, 16'h0, 1'b1, 16'h0000, 1'b1);
    issue(RD, 16'h0401, 16'h0, 16'h0, 1'b1, 16'h0000, 1'b1);
    issue(RD, 16'h0001, 16'h0, 16'h0, 1'b1, 16'h0000, 1'b0);
`else
    issue(WR, 16'h0401, 16'hAAAA, 16'h0, 1'b1, 16'h0000, 1'b0);
    issue(RD, 16'h0001, 16'h0, 16'h0, 1'b1, 16'hAAAA, 1'b0);
`endif
    issue(WR, 16'd1000, 16'h7777, 16'h0, 1'b1, 16'h0000, 1'b0);
    issue(RD, 16'd1000, 16'h0, 16'h0, 1'b1, 16'h7777, 1'b0);

    issue(CL, 16'h0, 16'h0, 16'h0, 1'b1, 16'h0000, 1'b0);
    wait_sweep(n);
    check("clear_busy_len", n, 32'd1024);
    check("clear_heap_ptr", 32'(heap_ptr), 32'd1);
    issue(RD, 16'h0010, 16'h0, 16'h0, 1'b1, 16'h0000, 1'b0);
    issue(RD, 16'd1000, 16'h0, 16'h0, 1'b1, 16'h0000, 1'b0);
    issue(RD, 16'h0001, 16'h0, 16'h0, 1'b1, 16'h0000, 1'b0);
    issue(RD, 16'h0000, 16'h0, 16'h0, 1'b1, NIL, 1'b0);

    issue(AL, 16'h0, 16'h0, 16'd1023, 1'b1, 16'd1, 1'b0);
    check("heap_ptr_full", 32'(heap_ptr), 32'd1024);
    issue(AL, 16'h0, 16'h0, 16'd1, 1'b1, 16'h0000, 1'b1);
    check("heap_ptr_overflow_kept", 32'(heap_ptr), 32'd1024);
    issue(AL, 16'h0, 16'h0, 16'd0, 1'b1, 16'h0400, 1'b0);

    // Abort a CLEAR partway through; requests while busy must be ignored.
    issue(WR, 16'd1000, 16'h1111, 16'h0, 1'b1, 16'h0000, 1'b0);
    issue(CL, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0000, 1'b0);
    req = 1'b1; op = RD; addr_in = 16'd1000;
    repeat (10) @(posedge clk);
    #1;
    req = 1'b0;
    repeat (490) @(posedge clk);
    #1;
    check("mid_sweep_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_sweep_reset_heap_ptr", 32'(heap_ptr), 32'd1);
    rst = 1'b0;
    wait_sweep(n);
    check("restart_sweep_len", n, 32'd1024);
    issue(RD, 16'd1000, 16'h0, 16'h0, 1'b1, 16'h0000, 1'b0);
    issue(RD, 16'h0000, 16'h0, 16'h0, 1'b1, NIL, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
